// File: rtl/mash_pkg.sv
// mash_pkg: shared constants and elaboration helpers for the MASH delta-sigma modulator
package mash_pkg;
  localparam int LFSR_W = 15;
  localparam int LFSR_TAP_HI = 14;
  localparam int LFSR_TAP_LO = 13;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;

  function automatic int min_out_width(input int order);
    return order == 3 ? 4 : order == 2 ? 3 : 2;
  endfunction

  function automatic bit order_ok(input int order);
    return (order >= 1) && (order <= 3);
  endfunction
endpackage

// File: rtl/mash_acc_stage.sv
// mash_acc_stage: registered wrap-around accumulator with carry-out and clock enable
module mash_acc_stage
  import mash_pkg::*;
#(
  parameter int P_WIDTH = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [P_WIDTH-1:0] i_add,
  input  logic               i_cin,
  output logic [P_WIDTH-1:0] o_acc,
  output logic               o_carry
);
  // one extra sum bit captures the overflow that becomes the stage carry
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) {o_carry, o_acc} <= '0;
    else if (i_en) {o_carry, o_acc} <= {1'b0, o_acc} + {1'b0, i_add} + {{P_WIDTH{1'b0}}, i_cin};
endmodule

// File: rtl/mash_ddsm.sv
// mash_ddsm: pipelined MASH 1-1-1 delta-sigma modulator with dither, enable and valid flag
module mash_ddsm
  import mash_pkg::*;
#(
  parameter int P_DATA_WIDTH = 6,
  parameter int P_ORDER      = 3,
  parameter int P_OUT_WIDTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic [P_DATA_WIDTH-1:0]       i_frac,
  input  logic                          i_dither_en,
  output logic signed [P_OUT_WIDTH-1:0] o_data,
  output logic                          o_valid
);
  localparam int L = P_ORDER + 1;

  if (!order_ok(P_ORDER)) begin : g_bad_order
    $error("mash_ddsm: P_ORDER must be 1, 2 or 3");
  end
  if (P_OUT_WIDTH < min_out_width(P_ORDER)) begin : g_bad_width
    $error("mash_ddsm: P_OUT_WIDTH too small for P_ORDER");
  end

  logic [P_ORDER:0][P_DATA_WIDTH-1:0] chain;
  logic [P_ORDER-1:0]                 c;
  logic [2:0]                         a;
  logic                               a2p, a3p, a3pp;
  logic [LFSR_W-1:0]                  lfsr;
  logic [2:0]                         cnt;
  logic signed [P_OUT_WIDTH-1:0]      y;
  logic                               unused_acc;

  assign chain[0]   = i_frac;
  assign unused_acc = ^chain[P_ORDER];

  genvar g;
  for (g = 0; g < 3; g++) begin : g_stage
    if (g < P_ORDER) begin : g_on
      localparam int D = P_ORDER - 1 - g;
      mash_acc_stage #(.P_WIDTH(P_DATA_WIDTH)) u_stage (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .i_add  (chain[g]),
        .i_cin  (g == 0 ? (i_dither_en & lfsr[0]) : 1'b0),
        .o_acc  (chain[g+1]),
        .o_carry(c[g])
      );
      if (D == 0) begin : g_nodly
        assign a[g] = c[g];
      end else begin : g_dly
        logic [D-1:0] dl;
        // earlier stages run ahead of later ones, so their carries wait to line up
        always_ff @(posedge i_clk or posedge i_rst)
          if (i_rst) dl <= '0;
          else if (i_en) dl <= D'({dl, c[g]});
        assign a[g] = dl[D-1];
      end
    end else begin : g_off
      assign a[g] = 1'b0;
    end
  end

  function automatic logic signed [P_OUT_WIDTH-1:0] ext(input logic b);
    return {{(P_OUT_WIDTH-1){1'b0}}, b};
  endfunction

  // noise-cancellation network over the aligned carries and their history
  always_comb y = ext(a[0]) + ext(a[1]) - ext(a2p) + ext(a[2]) - (ext(a3p) <<< 1) + ext(a3pp);

  // LFSR, carry history, fill counter and output advance together on enabled edges
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      lfsr    <= LFSR_SEED;
      a2p     <= 1'b0;
      a3p     <= 1'b0;
      a3pp    <= 1'b0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_en) begin
      lfsr   <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};
      a2p    <= a[1];
      a3p    <= a[2];
      a3pp   <= a3p;
      o_data <= y;
      if (!o_valid) begin
        cnt     <= cnt + 3'd1;
        o_valid <= (cnt == 3'(L - 1));
      end
    end
endmodule

// File: tb/tb_mash_ddsm.sv
// tb_mash_ddsm: scoreboard bench running order-1, -2 and -3 modulators side by side
module tb_mash_ddsm;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dith = 1'b0;
  logic [5:0] frac = '0;
  logic [3:0] d1, d2, d3;
  logic       v1, v2, v3;

  always #5 clk = ~clk;

  mash_ddsm #(.P_DATA_WIDTH(6), .P_ORDER(1), .P_OUT_WIDTH(4)) u1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_frac(frac), .i_dither_en(dith), .o_data(d1), .o_valid(v1));
  mash_ddsm #(.P_DATA_WIDTH(6), .P_ORDER(2), .P_OUT_WIDTH(4)) u2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_frac(frac), .i_dither_en(dith), .o_data(d2), .o_valid(v2));
  mash_ddsm #(.P_DATA_WIDTH(6), .P_ORDER(3), .P_OUT_WIDTH(4)) u3 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_frac(frac), .i_dither_en(dith), .o_data(d3), .o_valid(v3));

  int n_chk = 0;
  int n_err = 0;
  int macc[1:3][1:3];
  int c2p[1:3], c3p[1:3], c3pp[1:3];
  int sb1[$], sb2[$], sb3[$];
  int exp1, exp2, exp3;
  int n_en;
  logic [14:0] m_lfsr;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int o = 1; o <= 3; o++) begin
      for (int k = 1; k <= 3; k++) macc[o][k] = 0;
      c2p[o] = 0; c3p[o] = 0; c3pp[o] = 0;
    end
    sb1 = {0}; sb2 = {0, 0}; sb3 = {0, 0, 0};
    exp1 = 0; exp2 = 0; exp3 = 0;
    n_en = 0;
    m_lfsr = 15'h0001;
  endtask

  // classic unpipelined MASH step; the DUT's skewed pipeline must match it after latency
  task automatic mstep(input int o, input int f, input int cin, output int y);
    int s, ci, sum;
    int c[1:3];
    s = f; ci = cin;
    for (int k = 1; k <= 3; k++) c[k] = 0;
    for (int k = 1; k <= o; k++) begin
      sum = macc[o][k] + s + ci;
      c[k] = sum / 64;
      macc[o][k] = sum % 64;
      s = macc[o][k];
      ci = 0;
    end
    y = c[1] + c[2] - c2p[o] + c[3] - 2 * c3p[o] + c3pp[o];
    c3pp[o] = c3p[o]; c3p[o] = c[3]; c2p[o] = c[2];
  endtask

  task automatic check_all();
    chk("d1", int'($signed(d1)), exp1);
    chk("d2", int'($signed(d2)), exp2);
    chk("d3", int'($signed(d3)), exp3);
    chk("v1", int'(v1), int'(n_en >= 2));
    chk("v2", int'(v2), int'(n_en >= 3));
    chk("v3", int'(v3), int'(n_en >= 4));
  endtask

  task automatic cycle(input logic e, input logic [5:0] f, input logic dt);
    int y, cin;
    en = e; frac = f; dith = dt;
    @(posedge clk); #1;
    if (e) begin
      cin = dt ? int'(m_lfsr[0]) : 0;
      n_en++;
      mstep(1, int'(f), cin, y); sb1.push_back(y); exp1 = sb1.pop_front();
      mstep(2, int'(f), cin, y); sb2.push_back(y); exp2 = sb2.pop_front();
      mstep(3, int'(f), cin, y); sb3.push_back(y); exp3 = sb3.pop_front();
      m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
    end
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_all();
    rst = 1'b0;
  endtask

  int rec[100];
  int sum, bad, ns, nz, first;

  initial begin
    model_reset();
    // order-1 period-4 pattern, order-3 zero input, valid timing
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 6'd16, 1'b0);
    do_reset();
    for (int i = 0; i < 1000; i++) cycle(1'b1, 6'd0, 1'b0);
    // order-3 long-run mean and range
    do_reset();
    sum = 0; bad = 0; ns = 0;
    for (int i = 0; i < 4099; i++) begin
      cycle(1'b1, 6'd21, 1'b0);
      if (v3) begin
        sum += int'($signed(d3));
        if ($signed(d3) < -3 || $signed(d3) > 4) bad++;
        ns++;
      end
    end
    chk("o3_samples", ns, 4096);
    chk("o3_range_violations", bad, 0);
    chk("o3_sum_in_window", int'(sum >= 1341 && sum <= 1347), 1);
    // alternating enable, then random frac/dither/enable without flush
    do_reset();
    for (int i = 0; i < 200; i++) cycle(i % 2 == 0, 6'd32, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'($urandom_range(0, 3) != 0), 6'($urandom), 1'($urandom));
    // dither with zero input and LFSR period
    do_reset();
    nz = 0; first = 0;
    for (int i = 1; i <= 32767; i++) begin
      cycle(1'b1, 6'd0, 1'b1);
      if (d1 != 4'd0) nz++;
      if (first == 0 && u1.lfsr == 15'h0001) first = i;
    end
    chk("dither_nonzero", int'(nz > 0), 1);
    chk("lfsr_period", first, 32767);
    // mid-run async reset reproduces the power-on sequence
    do_reset();
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 6'd21, 1'b1);
      rec[i] = int'($signed(d3));
    end
    do_reset();
    for (int i = 0; i < 57; i++) cycle(1'b1, 6'd21, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("async_d1", int'(d1), 0);
    chk("async_d2", int'(d2), 0);
    chk("async_d3", int'(d3), 0);
    chk("async_v3", int'(v3), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 6'd21, 1'b1);
      chk("replay_d3", int'($signed(d3)), rec[i]);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mash_ddsm.md
Name: mash_ddsm

Overview:
- Parametrised MASH delta-sigma modulator built from 1 to 3 cascaded error-feedback accumulator stages, with a noise-cancellation network (NCN).
- Successor to the single-stage error-feedback block; adds selectable order, optional LSB dither, clock enable and an output-valid flag.
- Converts a static or slowly varying fractional word into a short signed integer stream whose mean equals i_frac / 2^P_DATA_WIDTH.
- Feeds the divider-control path of the fractional-N synthesiser.

Parameters:
- P_DATA_WIDTH, 6: width of the fractional input and of each accumulator.
- P_ORDER, 3: number of stages (1, 2 or 3); any other value is an elaboration error.
- P_OUT_WIDTH, 4: signed output width; must be at least 4 for order 3.

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: asynchronous active-high reset.
- i_en, input, 1: clock enable; all state advances only when high.
- i_frac, input, P_DATA_WIDTH: unsigned fractional word, sampled on enabled edges.
- i_dither_en, input, 1: when high, the LFSR bit is injected as stage-1 carry-in.
- o_data, output, P_OUT_WIDTH: signed two's-complement modulator output, registered.
- o_valid, output, 1: high once the pipeline has filled after reset.

Behaviour:
- Reset (async, i_rst high):
  - All accumulators, carries, delay lines and o_data go to 0; o_valid goes to 0.
  - The LFSR loads seed 15'h0001.
  - Release takes effect on the next edge.
- i_en low: every register holds, including the LFSR, fill counter and outputs.
- Stage k (k = 1..P_ORDER), on each enabled edge:
  - Update {c_k, acc_k} <= acc_k + s_k + cin_k, using a (P_DATA_WIDTH+1)-bit sum with natural wrap mod 2^P_DATA_WIDTH.
  - s_1 = i_frac. For k > 1, s_k = the registered acc_(k-1), i.e. the value before this edge.
  - cin_1 = i_dither_en ? lfsr[0] : 0. cin_k = 0 for k > 1.
- Pipeline skew: stage k sees data one edge later than stage k-1. c_k is delayed by (P_ORDER - k) enabled edges so all carries are time-aligned.
- NCN on the aligned carries a1..a3 (a-prime denotes the previous enabled-cycle value), registered into o_data:
  - Order 1: y = a1.
  - Order 2: y = a1 + a2 - a2'.
  - Order 3: y = a1 + a2 - a2' + a3 - 2*a3' + a3''.
  - Carry history registers reset to 0.
- Output range: order 1 gives 0..1; order 2 gives -1..2; order 3 gives -3..4. Arithmetic is done at P_OUT_WIDTH signed width, so no overflow is possible.
- Latency: L = P_ORDER + 1 enabled edges from i_frac sampling to its first contribution in o_data.
- o_valid:
  - A saturating counter counts enabled edges after reset.
  - o_valid rises on the L-th enabled edge and stays high until the next reset.
  - o_data before that edge is 0.
- LFSR:
  - 15-bit Fibonacci, polynomial x^15 + x^14 + 1.
  - Shifts on every enabled edge regardless of i_dither_en, so toggling dither never restarts the sequence.
- i_frac changes mid-run: accepted on any enabled edge with no flush; the accumulators carry their state across.
- Reset mid-operation: outputs clear immediately and asynchronously. After release the sequence repeats bit-exactly from the post-reset start.

Decomposition:
- Shared package mash_pkg holds:
  - LFSR width, polynomial taps and seed.
  - Minimum output-width constant per order.
  - The order-range check function.
- One sub-module: mash_acc_stage. It is the registered accumulator with carry-out, clock enable and async reset, instantiated P_ORDER times in a generate loop.
- The NCN, delay alignment, LFSR and valid counter stay in the top level.

Test Plan:
1. P_ORDER=1, i_frac=16, no dither, i_en=1:
   - o_valid rises on the 2nd edge.
   - o_data then repeats the period-4 pattern 0,0,0,1 (exactly one 1 per 4 samples).
2. P_ORDER=3, i_frac=0, no dither:
   - o_data stays 0 for 1000 cycles.
   - o_valid rises exactly on the 4th edge.
3. P_ORDER=3, i_frac=21, no dither, 4096 samples after valid:
   - Every o_data lies in -3..4.
   - The sum of o_data lies within 1344 ± 3.
4. P_ORDER=2, i_frac=32, i_en toggled 1,0,1,0 for 200 cycles:
   - o_data and all state hold on disabled cycles.
   - The enabled-cycle stream matches a run with i_en held at 1.
5. i_dither_en=1, i_frac=0, P_ORDER=1:
   - o_data is not identically 0.
   - The LFSR returns to 15'h0001 after exactly 32767 enabled edges.
6. Assert i_rst for one cycle mid-run at cycle 57:
   - o_data=0 and o_valid=0 immediately.
   - After release, the output sequence is bit-identical to the run from power-on.
